// File: rtl/reg_lock_scoreboard_if.sv
// reg_lock_scoreboard_if: launcher handshake, writeback bus and lock-status outputs of the scoreboard.
// master: the launcher/writeback side (drives clear, launch and writeback, reads status).
// slave: the scoreboard (reads requests, drives locks_o, outstanding_o, full_o and the sticky flags).
interface reg_lock_scoreboard_if #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 8
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_PENDING + 1);
  logic          clear_i;
  logic          launch_fire_i;
  logic          launch_wr_i;
  logic [RW-1:0] launch_rd_i;
  logic          wb_valid_i;
  logic [RW-1:0] wb_rd_i;
  logic [NUM_REGS-1:0] locks_o;
  logic [CW-1:0] outstanding_o;
  logic          full_o;
  logic          overflow_o;
  logic          underflow_o;
  modport master (
    output clear_i, launch_fire_i, launch_wr_i, launch_rd_i, wb_valid_i, wb_rd_i,
    input  locks_o, outstanding_o, full_o, overflow_o, underflow_o
  );
  modport slave (
    input  clear_i, launch_fire_i, launch_wr_i, launch_rd_i, wb_valid_i, wb_rd_i,
    output locks_o, outstanding_o, full_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/reg_lock_scoreboard.sv
// reg_lock_scoreboard: per-register pending-write counters producing the launcher lock vector.
// Ports: clk_i clock; arst_i async active-high reset; bus (slave) carries clear_i, the launch
// handshake (launch_fire_i/launch_wr_i/launch_rd_i), the writeback (wb_valid_i/wb_rd_i) and the
// registered outputs locks_o, outstanding_o, full_o, overflow_o, underflow_o.
module reg_lock_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  reg_lock_scoreboard_if.slave bus
);
  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_PENDING + 1);
  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic [CW-1:0] tot_q, tot_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          full, l, w, l_ok, cancel, inc, dec;
  assign full = tot_q == CW'(MAX_PENDING);
  always_comb begin
    l      = bus.launch_fire_i && bus.launch_wr_i && bus.launch_rd_i != '0;
    w      = bus.wb_valid_i && bus.wb_rd_i != '0;
    l_ok   = l && !full && cnt_q[bus.launch_rd_i] != CW'(MAX_PENDING);
    // an accepted launch and a writeback on the same register net out; the writeback is not an underflow
    cancel = l_ok && w && bus.launch_rd_i == bus.wb_rd_i;
    inc    = l_ok && !cancel;
    dec    = w && !cancel && cnt_q[bus.wb_rd_i] != '0;
    ovf_d  = !bus.clear_i && (ovf_q || (l && !l_ok));
    unf_d  = !bus.clear_i && (unf_q || (w && !cancel && cnt_q[bus.wb_rd_i] == '0));
    tot_d  = bus.clear_i ? '0 : tot_q + CW'(inc) - CW'(dec);
    for (int r = 0; r < NUM_REGS; r++)
      cnt_d[r] = bus.clear_i ? '0 :
                 cnt_q[r] + CW'(inc && bus.launch_rd_i == RW'(r)) - CW'(dec && bus.wb_rd_i == RW'(r));
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      cnt_q <= '{default: '0};
      tot_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tot_q <= tot_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_lock
    assign bus.locks_o[i] = cnt_q[i] != '0;
  end
  assign bus.outstanding_o = tot_q;
  assign bus.full_o        = full;
  assign bus.overflow_o    = ovf_q;
  assign bus.underflow_o   = unf_q;
endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// tb_reg_lock_scoreboard: directed and random checks of reg_lock_scoreboard against a count-based model.
module tb_reg_lock_scoreboard;
  localparam int NR = 32;
  localparam int MP = 8;
  localparam int RW = $clog2(NR);
  logic clk = 1'b0;
  logic arst_i;
  bit   clk_en = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   m_cnt [NR];
  int   m_tot;
  bit   m_ovf, m_unf;
  reg_lock_scoreboard_if #(.NUM_REGS(NR), .MAX_PENDING(MP)) bus ();
  reg_lock_scoreboard #(.NUM_REGS(NR), .MAX_PENDING(MP)) dut (
    .clk_i (clk),
    .arst_i(arst_i),
    .bus   (bus)
  );
  always #5 if (clk_en) clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [NR-1:0] m_locks();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_cnt[r] != 0;
    return v;
  endfunction
  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_tot = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask
  task automatic model_step(input bit clr, input bit lf, input bit lw, input int lrd, input bit wv, input int wrd);
    bit l, w, acc, paired;
    if (clr) begin
      model_reset();
      return;
    end
    l      = lf && lw && lrd != 0;
    w      = wv && wrd != 0;
    acc    = l && m_tot < MP && m_cnt[lrd] < MP;
    paired = acc && w && lrd == wrd;
    if (l && !acc) m_ovf = 1;
    if (w && !paired) begin
      if (m_cnt[wrd] == 0) m_unf = 1;
      else begin
        m_cnt[wrd]--;
        m_tot--;
      end
    end
    if (acc && !paired) begin
      m_cnt[lrd]++;
      m_tot++;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".locks"}, 64'(bus.locks_o), 64'(m_locks()));
    chk({tag, ".outstanding"}, 64'(bus.outstanding_o), 64'(m_tot));
    chk({tag, ".full"}, 64'(bus.full_o), 64'(m_tot == MP));
    chk({tag, ".overflow"}, 64'(bus.overflow_o), 64'(m_ovf));
    chk({tag, ".underflow"}, 64'(bus.underflow_o), 64'(m_unf));
  endtask
  task automatic cyc(input string tag, input bit clr, input bit lf, input bit lw, input int lrd, input bit wv, input int wrd);
    bus.clear_i       = clr;
    bus.launch_fire_i = lf;
    bus.launch_wr_i   = lw;
    bus.launch_rd_i   = RW'(lrd);
    bus.wb_valid_i    = wv;
    bus.wb_rd_i       = RW'(wrd);
    @(posedge clk);
    #1;
    model_step(clr, lf, lw, lrd, wv, wrd);
    check_all(tag);
    bus.clear_i       = 1'b0;
    bus.launch_fire_i = 1'b0;
    bus.launch_wr_i   = 1'b0;
    bus.wb_valid_i    = 1'b0;
  endtask
  task automatic launch(input string tag, input int rd);
    cyc(tag, 0, 1, 1, rd, 0, 0);
  endtask
  task automatic wback(input string tag, input int rd);
    cyc(tag, 0, 0, 0, 0, 1, rd);
  endtask
  initial begin
    int q [$];
    bit clr, lf, lw, wv;
    int lrd, wrd;
    bus.clear_i       = 1'b0;
    bus.launch_fire_i = 1'b0;
    bus.launch_wr_i   = 1'b0;
    bus.launch_rd_i   = '0;
    bus.wb_valid_i    = 1'b0;
    bus.wb_rd_i       = '0;
    arst_i = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    arst_i = 1'b0;
    clk_en = 1'b1;
    launch("l5", 5);
    chk("l5.locks_const", 64'(bus.locks_o), 64'h20);
    chk("l5.out_const", 64'(bus.outstanding_o), 64'd1);
    wback("w5", 5);
    for (int i = 0; i < 3; i++) launch("l7", 7);
    wback("w7a", 7);
    wback("w7b", 7);
    chk("w7b.lock7", 64'(bus.locks_o[7]), 64'd1);
    wback("w7c", 7);
    chk("w7c.locks_const", 64'(bus.locks_o), 64'd0);
    chk("w7c.out_const", 64'(bus.outstanding_o), 64'd0);
    launch("l3", 3);
    cyc("lw3", 0, 1, 1, 3, 1, 3);
    chk("lw3.lock3", 64'(bus.locks_o[3]), 64'd1);
    chk("lw3.out_const", 64'(bus.outstanding_o), 64'd1);
    chk("lw3.unf_const", 64'(bus.underflow_o), 64'd0);
    wback("w3", 3);
    launch("l0", 0);
    chk("l0.out_const", 64'(bus.outstanding_o), 64'd0);
    for (int r = 1; r <= MP; r++) launch("fill", r);
    chk("fill.full_const", 64'(bus.full_o), 64'd1);
    launch("over", 10);
    chk("over.ovf_const", 64'(bus.overflow_o), 64'd1);
    chk("over.out_const", 64'(bus.outstanding_o), 64'(MP));
    for (int r = 1; r <= MP; r++) wback("drain", r);
    wback("w9", 9);
    chk("w9.unf_const", 64'(bus.underflow_o), 64'd1);
    cyc("clr", 1, 1, 1, 4, 0, 0);
    chk("clr.locks_const", 64'(bus.locks_o), 64'd0);
    chk("clr.flags_const", 64'({bus.overflow_o, bus.underflow_o}), 64'd0);
    launch("l2a", 2);
    launch("l2b", 2);
    #2;
    arst_i = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    #1;
    arst_i = 1'b0;
    wback("w2post", 2);
    chk("w2post.unf_const", 64'(bus.underflow_o), 64'd1);
    cyc("clr2", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 15000; i++) begin
      clr = $urandom_range(0, 499) == 0;
      lf  = $urandom_range(0, 99) < 45;
      if (m_tot == MP && $urandom_range(0, 9) != 0) lf = 1'b0;
      lw  = $urandom_range(0, 3) != 0;
      lrd = $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NR - 1));
      wv  = $urandom_range(0, 99) < 40;
      q.delete();
      for (int r = 1; r < NR; r++) if (m_cnt[r] != 0) q.push_back(r);
      if (q.size() == 0 || $urandom_range(0, 19) == 0) wrd = $urandom_range(0, NR - 1);
      else wrd = q[$urandom_range(0, q.size() - 1)];
      if ($urandom_range(0, 9) == 0) wrd = lrd;
      cyc("soak", clr, lf, lw, lrd, wv, wrd);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
